alu_exec: RTL and testbench

- Execute-stage ALU. Consumes the 6-bit operation code from the ALU control decoder, plus operands from the register read and immediate path.
- Produces a registered result under a valid/ready handshake.
- Add, sub and or complete in one cycle. Shift-left-logical runs on an iterative one-bit-per-cycle shifter, so the downstream writeback logic must honour out_valid.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_serial_shifter.sv | 49 ++++
 rtl/alu_exec.sv | 154 +++++++++++++++
 tb/tb_alu_exec.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions. These are the funct codes (also used
//               by the ALU control decoder) and the execute-stage FSM state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation codes produced by the ALU control decoder
    localparam logic [5:0] FUNCT_ADD = 6'b001001;
    localparam logic [5:0] FUNCT_SUB = 6'b001010;
    localparam logic [5:0] FUNCT_SLL = 6'b100001;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    // Execute-stage FSM encoding
    localparam int unsigned STATE_W  = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [STATE_W-1:0] ST_HOLD  = 2'd2;

    // True when the code is one of the four operations this ALU implements
    function automatic logic funct_is_legal(input logic [5:0] f);
        return (f == FUNCT_ADD) || (f == FUNCT_SUB) ||
               (f == FUNCT_SLL) || (f == FUNCT_OR);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_serial_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_shifter
// Description : Iterative logical left shifter that moves one bit per cycle.
//               A start pulse loads the operand and the shift count. o_done
//               is high in the cycle whose clock edge performs the final
//               shift. o_shifted then carries the finished value.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_shifter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [DATA_W-1:0]  i_load_val,
    input  logic [SHAMT_W-1:0] i_load_amt,
    output logic               o_done,
    output logic [DATA_W-1:0]  o_shifted
);

    localparam logic [SHAMT_W-1:0] c_cnt_one = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]  r_work;
    logic [SHAMT_W-1:0] r_cnt;

    // Load on start, otherwise shift one bit and count down until exhausted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_work <= i_load_val;
            r_cnt  <= i_load_amt;
        end else if (r_cnt != '0) begin
            r_work <= r_work << 1;
            r_cnt  <= r_cnt - c_cnt_one;
        end
    end

    // Last iteration is flagged one cycle early so the owner can capture it
    always_comb begin
        o_done    = (r_cnt == c_cnt_one);
        o_shifted = r_work << 1;
    end

endmodule : alu_serial_shifter
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec
// Description : Execute-stage ALU with a valid/ready handshake on both sides.
//               add/sub/or (and sll by zero) finish in one cycle. sll by
//               N>0 goes through the serial shifter and takes N+1 cycles.
//               The result, zero and illegal flags are registered and held
//               until the consumer takes them.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         funct,
    input  logic [DATA_W-1:0]  src_a,
    input  logic [DATA_W-1:0]  src_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               illegal
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;

    logic [DATA_W-1:0]  r_result;
    logic               r_zero;
    logic               r_illegal;

    logic               w_accept;
    logic               w_multi_shift;
    logic [DATA_W-1:0]  w_op_res;
    logic               w_op_illegal;
    logic               w_shift_done;
    logic [DATA_W-1:0]  w_shift_val;

    // Accept decode. Only sll with a non-zero amount needs the iterative path.
    always_comb begin
        w_accept      = in_valid && in_ready;
        w_multi_shift = (funct == FUNCT_SLL) && (shamt != '0);
    end

    // Single-cycle result. An sll by zero passes src_b through unchanged.
    always_comb begin
        w_op_res     = '0;
        w_op_illegal = !funct_is_legal(funct);
        case (funct)
            FUNCT_ADD: w_op_res = src_a + src_b;
            FUNCT_SUB: w_op_res = src_a - src_b;
            FUNCT_OR:  w_op_res = src_a | src_b;
            FUNCT_SLL: w_op_res = src_b;
            default:   w_op_res = '0;
        endcase
    end

    alu_serial_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_accept && w_multi_shift),
        .i_load_val (src_b),
        .i_load_amt (shamt),
        .o_done     (w_shift_done),
        .o_shifted  (w_shift_val)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic. An accept in HOLD drains and reloads in one edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_multi_shift ? ST_SHIFT : ST_HOLD;
                end
            end
            ST_SHIFT: begin
                if (w_shift_done) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    w_state_next = w_multi_shift ? ST_SHIFT : ST_HOLD;
                end else if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs. Nothing is accepted while reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready = !rst;
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = !rst && out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Output register loads only on a single-cycle accept or shift completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept && !w_multi_shift) begin
            r_result  <= w_op_res;
            r_zero    <= (w_op_res == '0);
            r_illegal <= w_op_illegal;
        end else if ((r_state == ST_SHIFT) && w_shift_done) begin
            r_result  <= w_shift_val;
            r_zero    <= (w_shift_val == '0);
            r_illegal <= 1'b0;
        end
    end

    // Drive the registered results to the ports
    always_comb begin
        result  = r_result;
        zero    = r_zero;
        illegal = r_illegal;
    end

endmodule : alu_exec
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec
// Description : Self-checking bench for alu_exec. It uses a scoreboard of
//               expected results, each with the cycle at which out_valid
//               must first rise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec;

    localparam logic [5:0] c_add = 6'b001001;
    localparam logic [5:0] c_sub = 6'b001010;
    localparam logic [5:0] c_sll = 6'b100001;
    localparam logic [5:0] c_or  = 6'b100101;
    localparam logic [5:0] c_bad = 6'b111111;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  funct;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;
    bit   seen    = 1'b0;

    alu_exec #(
        .DATA_W  (32),
        .SHAMT_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .src_a     (src_a),
        .src_b     (src_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: {illegal, result}
    function automatic logic [32:0] model(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        case (f)
            c_add:   return {1'b0, a + b};
            c_sub:   return {1'b0, a - b};
            c_or:    return {1'b0, a | b};
            c_sll:   return {1'b0, b << sh};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // Called at posedge+1. Presents an op, waits for acceptance and records the expectation.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] exp_res,
                         input logic exp_ill, input int lat);
        int n;
        exp_t e;
        in_valid = 1'b1;
        funct    = f;
        src_a    = a;
        src_b    = b;
        shamt    = sh;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept", {31'b0, in_ready}, 32'h1);
        if (in_ready) begin
            e.res  = exp_res;
            e.zero = (exp_res == 32'h0);
            e.ill  = exp_ill;
            e.cyc  = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for the scoreboard to empty. Returns at posedge+1.
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain", sb.size(), 0);
        sb.delete();
        seen = 1'b0;
        #1;
    endtask

    // Output monitor. Checks the first-rise cycle and the data at each take.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check_eq("spurious_valid", {31'b0, out_valid}, 32'h0);
            end else begin
                if (!seen) begin
                    check_eq("latency", cyc, sb[0].cyc);
                    seen = 1'b1;
                end
                if (out_ready) begin
                    check_eq("result",  result, sb[0].res);
                    check_eq("zero",    {31'b0, zero}, {31'b0, sb[0].zero});
                    check_eq("illegal", {31'b0, illegal}, {31'b0, sb[0].ill});
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [5:0] ftab [5];
        logic [32:0] m;
        int n_low;
        ftab[0] = c_add; ftab[1] = c_sub; ftab[2] = c_or; ftab[3] = c_sll; ftab[4] = 6'b000000;

        rst = 1'b1; in_valid = 1'b0; funct = '0; src_a = '0; src_b = '0; shamt = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check_eq("rst_result",    result, 32'h0);
        check_eq("rst_zero",      {31'b0, zero}, 32'h0);
        check_eq("rst_illegal",   {31'b0, illegal}, 32'h0);
        check_eq("rst_in_ready",  {31'b0, in_ready}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // add wraps
        issue(c_add, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, 32'h0000_0001, 1'b0, 1);
        drain();

        // sub to zero, then or back-to-back with no bubble
        issue(c_sub, 32'h1234_5678, 32'h1234_5678, 5'd0, 32'h0, 1'b0, 1);
        issue(c_or,  32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 32'hF0F0_0F0F, 1'b0, 1);
        drain();

        // sll by 4: in_ready low for 4 cycles
        issue(c_sll, 32'h0, 32'h0000_0003, 5'd4, 32'h0000_0030, 1'b0, 5);
        n_low = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) break;
            n_low++;
        end
        check_eq("sll4_busy_cycles", n_low, 4);
        @(posedge clk);
        drain();

        // sll by 31 and by 0
        issue(c_sll, 32'h0, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0, 32);
        drain();
        issue(c_sll, 32'h0, 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5, 1'b0, 1);
        drain();

        // backpressure, then drain and accept on the same edge
        out_ready = 1'b0;
        issue(c_add, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_out_valid", {31'b0, out_valid}, 32'h1);
            check_eq("bp_result",    result, 32'd30);
            check_eq("bp_in_ready",  {31'b0, in_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(c_or, 32'h1, 32'h2, 5'd0, 32'h3, 1'b0, 1);
        drain();

        // reset in the middle of a long shift
        issue(c_sll, 32'h0, 32'h1, 5'd20, 32'h0010_0000, 1'b0, 21);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        seen = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_out_valid", {31'b0, out_valid}, 32'h0);
        check_eq("midrst_result",    result, 32'h0);
        check_eq("midrst_in_ready",  {31'b0, in_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_idle", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        #1;

        // illegal code
        issue(c_bad, 32'h5, 32'h6, 5'd0, 32'h0, 1'b1, 1);
        drain();

        // short random mix
        for (int k = 0; k < 10; k++) begin
            logic [5:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  sh;
            f  = ftab[$urandom_range(0, 4)];
            a  = $urandom;
            b  = $urandom;
            sh = 5'($urandom_range(0, 7));
            m  = model(f, a, b, sh);
            issue(f, a, b, sh, m[31:0], m[32], (f == c_sll && sh != 5'd0) ? int'(sh) + 1 : 1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule : tb_alu_exec
`default_nettype wire
